// File: rtl/vend_output_handler.sv
// Output stage of the vending datapath: registered item decode and change
// calculation. On a completed transaction exactly one item is dispensed and
// change is returned; insufficient funds refund the full amount instead.
module vend_output_handler #(
    parameter int MONEY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               end_trans,
    input  logic [MONEY_W-1:0] sum_money,
    input  logic [MONEY_W-1:0] price,
    input  logic [1:0]         item_select,
    output logic               item_1,
    output logic               item_2,
    output logic               item_3,
    output logic               item_4,
    output logic [MONEY_W-1:0] change
);

    logic [3:0]         items_d, items_q;
    logic [MONEY_W-1:0] change_d, change_q;

    // Money to return: the difference when funds cover the price, otherwise
    // the whole amount. The subtraction is only taken when it cannot wrap.
    function automatic logic [MONEY_W-1:0] change_amount(
        input logic [MONEY_W-1:0] money,
        input logic [MONEY_W-1:0] cost
    );
        if (money >= cost) begin
            return money - cost;
        end
        return money;
    endfunction

    // One-hot item decode for a given select code.
    function automatic logic [3:0] item_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[sel] = 1'b1;
        return oh;
    endfunction

    // Next-state decode: dispense only on a funded transaction, idle clears all.
    always_comb begin
        items_d  = 4'b0000;
        change_d = '0;
        if (end_trans) begin
            change_d = change_amount(sum_money, price);
            if (sum_money >= price) begin
                items_d = item_onehot(item_select);
            end
        end
    end

    // Output registers; reset clears them immediately without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            items_q  <= 4'b0000;
            change_q <= '0;
        end else begin
            items_q  <= items_d;
            change_q <= change_d;
        end
    end

    assign item_1 = items_q[0];
    assign item_2 = items_q[1];
    assign item_3 = items_q[2];
    assign item_4 = items_q[3];
    assign change = change_q;

endmodule

// File: tb/tb_vend_output_handler.sv
// Scoreboard bench for vend_output_handler: stimulus pushes the expected
// response per applied vector, a monitor pops and compares after each edge.
module tb_vend_output_handler;

    localparam int MONEY_W = 8;

    logic               clk;
    logic               rst_n;
    logic               end_trans;
    logic [MONEY_W-1:0] sum_money;
    logic [MONEY_W-1:0] price;
    logic [1:0]         item_select;
    logic               item_1, item_2, item_3, item_4;
    logic [MONEY_W-1:0] change;

    typedef struct {
        int               tag;
        logic [3:0]       items;
        logic [MONEY_W-1:0] chg;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   next_tag;

    vend_output_handler #(.MONEY_W(MONEY_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .end_trans  (end_trans),
        .sum_money  (sum_money),
        .price      (price),
        .item_select(item_select),
        .item_1     (item_1),
        .item_2     (item_2),
        .item_3     (item_3),
        .item_4     (item_4),
        .change     (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge and record what the next rising
    // edge must produce.
    task automatic apply(input logic en, input logic [1:0] sel,
                         input logic [MONEY_W-1:0] s, input logic [MONEY_W-1:0] p,
                         input logic [3:0] e_items, input logic [MONEY_W-1:0] e_chg);
        exp_t e;
        @(negedge clk);
        end_trans   = en;
        item_select = sel;
        sum_money   = s;
        price       = p;
        e.tag   = next_tag;
        e.items = e_items;
        e.chg   = e_chg;
        next_tag++;
        exp_q.push_back(e);
    endtask

    // Direct check used while reset is asserted (no clock edge involved).
    task automatic check_now(input string name);
        n_vec++;
        if ({item_4, item_3, item_2, item_1} !== 4'b0000 || change !== '0) begin
            n_err++;
            $display("FAIL %s: items=%b change=%0d, required items=0000 change=0",
                     name, {item_4, item_3, item_2, item_1}, change);
        end
    endtask

    // Wait for the scoreboard to drain, with a bound.
    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d vectors never compared, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: outputs are valid 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({item_4, item_3, item_2, item_1} !== e.items || change !== e.chg) begin
                    n_err++;
                    $display("FAIL vec%0d: items=%b change=%0d, required items=%b change=%0d",
                             e.tag, {item_4, item_3, item_2, item_1}, change, e.items, e.chg);
                end
            end
        end
    end

    initial begin
        int s, p, sel;
        n_vec = 0;
        n_err = 0;
        next_tag = 0;
        rst_n = 1'b1;
        end_trans = 1'b1;
        item_select = 2'd0;
        sum_money = 8'd50;
        price = 8'd20;

        // Reset asserted between clock edges must clear outputs at once.
        #1 rst_n = 1'b0;
        #2 check_now("reset_async");
        repeat (3) @(posedge clk);
        #1 check_now("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        end_trans = 1'b0;

        // Directed vectors with hand-computed results.
        apply(1'b1, 2'd2, 8'd137, 8'd137, 4'b0100, 8'd0);    // exact payment
        apply(1'b1, 2'd0, 8'd200, 8'd40,  4'b0001, 8'd160);  // overpayment
        apply(1'b0, 2'd3, 8'd99,  8'd7,   4'b0000, 8'd0);    // idle
        apply(1'b1, 2'd3, 8'd60,  8'd100, 4'b0000, 8'd60);   // insufficient
        apply(1'b1, 2'd1, 8'd255, 8'd0,   4'b0010, 8'd255);  // price 0, max money
        apply(1'b0, 2'd1, 8'd255, 8'd0,   4'b0000, 8'd0);    // drop end_trans
        apply(1'b1, 2'd3, 8'd255, 8'd255, 4'b1000, 8'd0);    // both max
        apply(1'b1, 2'd0, 8'd0,   8'd1,   4'b0000, 8'd0);    // zero money, short
        apply(1'b1, 2'd2, 8'd254, 8'd255, 4'b0000, 8'd254);  // short by one
        apply(1'b1, 2'd0, 8'd0,   8'd0,   4'b0001, 8'd0);    // free item, no money
        apply(1'b1, 2'd1, 8'd10,  8'd3,   4'b0010, 8'd7);    // held high, new inputs
        apply(1'b1, 2'd2, 8'd90,  8'd45,  4'b0100, 8'd45);   // held high, new inputs
        drain();

        // Overpayment sweep with random select and strictly larger money.
        for (int i = 0; i < 255; i++) begin
            s   = $urandom_range(1, 255);
            p   = $urandom_range(0, s - 1);
            sel = $urandom_range(0, 3);
            apply(1'b1, sel[1:0], s[7:0], p[7:0], 4'(1 << sel), 8'(s - p));
        end
        drain();

        // Reset in the middle of an active dispense clears without a clock.
        apply(1'b1, 2'd1, 8'd30, 8'd10, 4'b0010, 8'd20);
        drain();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_now("reset_mid_trans");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 2'd0, 8'd1, 8'd1, 4'b0000, 8'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
